// File: rtl/ohr_accumulator_if.sv
// ---------------------------------------------------------------------------
// ohr_accumulator_if
//   Handshake/data bundle for the one-hot residue accumulator.
//   Parameter M : modulus (residue width in bits).
//   Signals:
//     IN_VALID / IN_READY   : request handshake (producer -> accumulator)
//     OP[1:0]               : 00 A+B, 01 A-B, 10 ACC+A, 11 load ACC=A
//     A, B [M-1:0]          : one-hot residue operands
//     OUT_VALID / OUT_READY : result handshake (accumulator -> consumer)
//     SUM [M-1:0]           : one-hot result residue
//     THERMO [M-2:0]        : thermometer code of the result
//     WRAP                  : carry (sum >= M) or borrow (A < B)
//     ERR                   : a used operand was not exactly one-hot
//   master modport = producer/consumer side, slave modport = accumulator.
// ---------------------------------------------------------------------------
interface ohr_accumulator_if #(
    parameter int M = 7
);
    logic         IN_VALID;
    logic         IN_READY;
    logic [1:0]   OP;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [M-1:0] SUM;
    logic [M-2:0] THERMO;
    logic         WRAP;
    logic         ERR;

    modport master (
        output IN_VALID, OP, A, B, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, THERMO, WRAP, ERR
    );

    modport slave (
        input  IN_VALID, OP, A, B, OUT_READY,
        output IN_READY, OUT_VALID, SUM, THERMO, WRAP, ERR
    );
endinterface

// File: rtl/ohr_accumulator.sv
// ---------------------------------------------------------------------------
// ohr_accumulator
//   Registered one-hot residue (mod M) adder/subtractor with an accumulator.
//   All arithmetic is done directly on one-hot vectors as an OR of pairwise
//   ANDs; no binary encoding is ever formed.
//   Parameter M : modulus, 3..32.
//   Ports:
//     CLK   : clock, rising edge
//     RST_N : asynchronous active-low reset
//     bus   : ohr_accumulator_if.slave (handshakes, operands, results)
//   Latency 1 cycle, throughput 1 per cycle when OUT_READY is held high.
// ---------------------------------------------------------------------------
module ohr_accumulator #(
    parameter int M = 7
) (
    input  logic                CLK,
    input  logic                RST_N,
    ohr_accumulator_if.slave    bus
);

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    // Registered state
    logic         out_valid_reg;
    logic [M-1:0] sum_reg;
    logic [M-2:0] thermo_reg;
    logic         wrap_reg;
    logic         err_reg;
    logic [M-1:0] acc_reg;

    // Combinational
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [1:0]   op;
    logic [M-1:0] operand_b;
    logic [M-1:0] add_sum;
    logic [M-1:0] sub_sum;
    logic [M-1:0] add_wrap_term;
    logic [M-1:0] sub_borrow_term;
    logic         add_wrap;
    logic         sub_borrow;
    logic [M-1:0] sum_next;
    logic [M-2:0] thermo_next;
    logic         wrap_next;
    logic         err_next;
    logic         in_ready;
    logic         accept;
    logic         acc_load;

    function automatic logic is_onehot(input logic [M-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    assign a  = bus.A;
    assign b  = bus.B;
    assign op = bus.OP;

    // Second addend: the accumulator for OP 10, otherwise B.
    assign operand_b = (op == 2'b10) ? acc_reg : b;

    // For result bit gi, gj walks over the index of A:
    //   add: r = gi  <=>  B index = (gi - gj) mod M
    //   sub: r = gi  <=>  B index = (gj - gi) mod M
    // The wrap/borrow terms are per A index gi: carry when B index >= M-gi,
    // borrow when B index > gi.
    for (genvar gi = 0; gi < M; gi++) begin : g_bit
        logic [M-1:0] add_sel;
        logic [M-1:0] sub_sel;
        logic [M-1:0] add_wrap_sel;
        logic [M-1:0] sub_borrow_sel;

        for (genvar gj = 0; gj < M; gj++) begin : g_pair
            assign add_sel[gj]        = operand_b[(gi - gj + M) % M];
            assign sub_sel[gj]        = operand_b[(gj - gi + M) % M];
            assign add_wrap_sel[gj]   = (gj + gi >= M) ? operand_b[gj] : 1'b0;
            assign sub_borrow_sel[gj] = (gj > gi)      ? operand_b[gj] : 1'b0;
        end

        assign add_sum[gi]         = |(a & add_sel);
        assign sub_sum[gi]         = |(a & sub_sel);
        assign add_wrap_term[gi]   = a[gi] & (|add_wrap_sel);
        assign sub_borrow_term[gi] = a[gi] & (|sub_borrow_sel);
    end

    assign add_wrap   = |add_wrap_term;
    assign sub_borrow = |sub_borrow_term;

    always_comb begin
        // B only matters for the two-operand ops.
        err_next = !is_onehot(a) || (!op[1] && !is_onehot(b));
        case (op)
            2'b00:   begin sum_next = add_sum; wrap_next = add_wrap;   end
            2'b01:   begin sum_next = sub_sum; wrap_next = sub_borrow; end
            2'b10:   begin sum_next = add_sum; wrap_next = add_wrap;   end
            default: begin sum_next = a;       wrap_next = 1'b0;       end
        endcase
        if (err_next) begin
            sum_next  = '0;
            wrap_next = 1'b0;
        end
    end

    // Thermometer bit k is set when the result index exceeds k.
    for (genvar gi = 0; gi < M - 1; gi++) begin : g_thermo
        assign thermo_next[gi] = |sum_next[M-1:gi+1];
    end

    assign in_ready = !out_valid_reg || bus.OUT_READY;
    assign accept   = bus.IN_VALID && in_ready;
    assign acc_load = accept && op[1] && !err_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            thermo_reg    <= '0;
            wrap_reg      <= 1'b0;
            err_reg       <= 1'b0;
            acc_reg       <= ONE;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                sum_reg       <= sum_next;
                thermo_reg    <= thermo_next;
                wrap_reg      <= wrap_next;
                err_reg       <= err_next;
            end else if (out_valid_reg && bus.OUT_READY) begin
                out_valid_reg <= 1'b0;
            end
            if (acc_load) begin
                acc_reg <= sum_next;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_reg;
    assign bus.SUM       = sum_reg;
    assign bus.THERMO    = thermo_reg;
    assign bus.WRAP      = wrap_reg;
    assign bus.ERR       = err_reg;

endmodule

// File: doc/ohr_accumulator.md
Name: ohr_accumulator

Overview:
- Parametrised, registered successor to the team's combinational mod-7 one-hot residue (OHR) adder.
- Operates on one-hot residues modulo M and provides four operations: add, subtract, accumulate and load.
- Holds a one-hot accumulator register and reports each result as both one-hot and thermometer code.
- Uses valid/ready handshakes on input and output and sits between OHR datapath stages in the residue-number-system pipeline.

Parameters:
- M, 7, modulus; residue width in bits; legal range 3..32.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand/op presented.
- IN_READY  output  1  block can accept a transaction this cycle.
- OP  input  2  00 SUM=A+B; 01 SUM=A-B; 10 ACC=ACC+A; 11 ACC=A (load).
- A  input  M  one-hot residue operand, bit i set = value i.
- B  input  M  one-hot residue operand; used only for OP 00/01.
- OUT_VALID  output  1  result registered and held.
- OUT_READY  input  1  downstream accepts the result.
- SUM  output  M  one-hot result residue.
- THERMO  output  M-1  thermometer code of the result: r ones, LSB-aligned.
- WRAP  output  1  carry/borrow: sum reached or exceeded M, or subtraction borrowed.
- ERR  output  1  a used operand was not exactly one-hot.

Behaviour:
- **Reset (RST_N low, asynchronous).** OUT_VALID=0, SUM=0, THERMO=0, WRAP=0, ERR=0, ACC=one-hot 0 (bit0 set). Releasing reset changes nothing until the first accepted transaction.
- **Handshake.**
  - IN_READY = !OUT_VALID | OUT_READY, combinational; there is no other source of backpressure.
  - Accept = IN_VALID & IN_READY. On accept, the result registers load at the next rising edge and OUT_VALID=1. Latency is 1 cycle.
  - Output transfer = OUT_VALID & OUT_READY. On transfer with no new accept, OUT_VALID goes to 0. Simultaneous transfer and accept gives back-to-back throughput of 1 per cycle.
  - While OUT_VALID=1 and OUT_READY=0, SUM, THERMO, WRAP and ERR hold stable and IN_READY=0.
- **Arithmetic.** Let i = index of A, j = index of B or of ACC.
  - Add (OP 00, OP 10): r = (i+j) mod M; WRAP = (i+j >= M).
  - Subtract (OP 01): r = (i-j) mod M; WRAP = (i < j).
  - Each result is an OR of pairwise ANDs of the operand bits, generalising the mod-7 adder to M; there is no binary encode/decode.
  - THERMO[k] = (k < r) for k = 0..M-2, so r=0 gives all zeros and r=M-1 gives all ones.
- **Accumulator.**
  - OP 10: ACC <= one-hot r; SUM shows the new ACC.
  - OP 11: ACC <= A; SUM = A; WRAP = 0.
  - OP 00/01 never modify ACC.
- **One-hot check.** Check A for every op, and B only for OP 00/01; a zero vector or more than one set bit is illegal.
  - On an illegal operand the transaction is still accepted.
  - ERR=1, SUM=0, THERMO=0, WRAP=0, and ACC is unchanged (including for OP 10/11).
  - ERR applies per result; the next legal result clears it.
- **Boundary cases.**
  - Reset asserted mid-transaction discards the pending result and ACC returns to residue 0.
  - IN_VALID without IN_READY has no effect.
  - Operands may change freely while IN_READY=0.
  - There is no internal state beyond the output registers and ACC.

Test Plan:
- **Reset.** Assert RST_N=0 mid-stream with OUT_VALID=1 -> OUT_VALID=0, SUM=0, THERMO=0, ERR=0. Then OP=10 with A=0000001 -> SUM=0000001 (ACC was 0).
- **Exhaustive add/sub, M=7.** All 49 A,B pairs with OP=00 and OP=01, OUT_READY=1. Example: A=3,B=5 -> SUM=0000010 (1), WRAP=1, THERMO=000001. Check against a reference model; 1 result per cycle back-to-back.
- **Accumulate wrap.** Load 11 A=6, then 10 A=2 -> SUM=0000010 (1), WRAP=1. Then 10 A=5 -> SUM=1000000 (6), WRAP=0, THERMO=111111.
- **Backpressure.** OUT_READY=0 for 4 cycles after an accept -> IN_READY=0 and outputs stable. Release -> transfer and new accept occur in the same cycle.
- **Illegal operand.** OP=10 with A=0000110 -> ERR=1, SUM=0, ACC unchanged. OP=00 with B=0 -> ERR=1. The next legal op clears ERR.
- **Parameter sweep.** M=3 and M=13, random legal ops with random OUT_READY -> match the model; THERMO width is M-1.
